fu_rr_arbiter: RTL and testbench
================================

# fu_rr_arbiter

Round-robin issue arbiter that shares one non-pipelined functional unit (multiplier/divider class) among N reservation-station requesters. Each cycle it picks one requesting entry with a rotating priority pointer. It holds a registered one-hot grant until the FU accepts it, then keeps the FU marked busy for its fixed occupancy. It sits between the RS ready-vector and the FU issue port and replaces a static priority select for that port.

## Interface
- N, default 16: number of requesters; power of two, 2..64.
- LAT, default 4: FU occupancy in cycles per accepted op; integer ≥ 1.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N  per-entry request; level-sensitive; may drop at any time (squash).
- fu_ready  in  1  FU accepts the presented grant this cycle.
- flush  in  1  synchronous pipeline flush.
- gnt  out  N  registered one-hot grant; all zero when gnt_valid=0.
- gnt_idx  out  $clog2(N)  binary index of gnt; 0 when gnt_valid=0.
- gnt_valid  out  1  a grant is presented to the FU.
- issue  out  1  combinational: gnt_valid & fu_ready (transfer this cycle).
- busy  out  1  FU occupied by a previously accepted op.

## Operation
- States: IDLE, GRANT, BUSY. Registers: state, gnt, gnt_idx, ptr ($clog2(N) bits), cnt ($clog2(LAT+1) bits).
- select(p, m): over r = req & m, the first set bit searched from index p upward, wrapping N-1→0. Returns a one-hot vector and an index. Empty if r=0.
- IDLE: if |req, load gnt/gnt_idx = select(ptr, all-ones), then go to GRANT. Otherwise stay.
- GRANT: gnt_valid=1; gnt is held stable until it leaves GRANT.
  - Withdrawal, when req[gnt_idx]=0 and fu_ready=0: clear the grant and go to IDLE. ptr is unchanged.
  - Transfer, when fu_ready=1 (regardless of req): issue=1 and ptr ← (gnt_idx+1) mod N.
    - If LAT>1: cnt ← LAT-1 and go to BUSY.
    - If LAT=1: re-arbitrate the same cycle with select(gnt_idx+1, ~gnt). If it is non-empty, stay in GRANT with the new grant. Otherwise go to IDLE.
- BUSY: busy=1, gnt_valid=0, gnt=0; cnt decrements each cycle.
  - When cnt=1 and |req: load select(ptr, all-ones) and go to GRANT.
  - When cnt=1 and no req: go to IDLE.
- flush: highest priority over every transition. Next state is IDLE; gnt, gnt_idx and cnt are cleared. ptr is retained. Flush during BUSY abandons the occupancy count, because the FU is flushed too.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid and busy are never both 1.
  - At most one issue per LAT cycles.
- Fairness: after an entry is served, every other continuously requesting entry is served before it is served again.

## Timing
- Reset (async assert, deasserts sync to clock): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, busy=0, issue=0, ptr=0, cnt=0.
- Request latency: req seen in IDLE at cycle t → gnt_valid=1 at t+1.
- Accept at cycle t with LAT>1:
  - busy=1 during t+1 .. t+LAT-1.
  - The next gnt_valid is earliest at t+LAT.
- Accept at cycle t with LAT=1: a different requester can be granted at t+1 (back-to-back issue).
- issue depends combinationally on fu_ready. All other outputs are registered.
- Withdrawal and accept in the same cycle: accept wins, because fu_ready has priority.
- Flush at cycle t: all outputs are idle at t+1. A req present at t+1 is granted at t+2.

## Test plan
- Reset, then N=16, LAT=4, req=0x0010, fu_ready=1 → gnt_valid at cycle 1, gnt=0x0010, gnt_idx=4, issue at cycle 1, busy during cycles 2–4, ptr=5.
- Fairness: req=0xFFFF held, fu_ready=1, LAT=1 → gnt_idx sequence 0,1,2,…,15,0 with one issue every cycle; gnt is one-hot every cycle.
- Wrap: ptr=15 (after serving 14), req=0x8001 → grant 15, then grant 0, then grant 15.
- Withdrawal: grant on idx 3 with fu_ready=0, then req[3] drops → gnt_valid=0 next cycle; ptr is unchanged; req[5] is then granted before req[2].
- Flush mid-BUSY: LAT=4, accept at t, flush at t+1 → busy=0 at t+2; the pending req is granted at t+3; ptr keeps its post-accept value.
- Async reset asserted in GRANT between edges → all outputs zero immediately; after release, the req scan restarts from index 0.

Source files
------------

// File: rtl/fu_rr_arbiter.sv
// Round-robin issue arbiter sharing one non-pipelined functional unit among
// N reservation-station requesters. It presents a registered one-hot grant
// until the FU accepts it, then tracks the FU occupancy for LAT cycles.
module fu_rr_arbiter #(
   parameter  int N   = 16,
   parameter  int LAT = 4,
   localparam int IW  = $clog2(N),
   localparam int CW  = $clog2(LAT + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [N-1:0]  i_req,
   input  logic          i_fu_ready,
   input  logic          i_flush,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_gnt_idx,
   output logic          o_gnt_valid,
   output logic          o_issue,
   output logic          o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY} state_t;

   state_t        r_state, w_state_nxt;
   logic [N-1:0]  r_gnt, w_gnt_nxt;
   logic [IW-1:0] r_gnt_idx, w_gnt_idx_nxt;
   logic [IW-1:0] r_ptr, w_ptr_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;

   logic [IW-1:0] w_ptr_inc;
   logic          w_a_found, w_b_found;
   logic [IW-1:0] w_a_idx, w_b_idx;

   // First set bit of r searched from p upward, wrapping N-1 -> 0.
   // Returns {found, index}; N is a power of two so the wrap is a truncation.
   function automatic logic [IW:0] f_sel(input logic [N-1:0] r, input logic [IW-1:0] p);
      logic          found;
      logic [IW-1:0] idx;
      logic [IW-1:0] k;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         k = p + IW'(i);
         if (!found && r[k]) begin
            found = 1'b1;
            idx   = k;
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [N-1:0] f_oh(input logic [IW-1:0] idx);
      logic [N-1:0] one;
      one = {{(N-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

   assign w_ptr_inc = r_gnt_idx + 1'b1;

   // Two candidate picks: a fresh scan from the pointer, and the same-cycle
   // re-arbitration after a transfer that skips the entry just served.
   always_comb begin
      {w_a_found, w_a_idx} = f_sel(i_req, r_ptr);
      {w_b_found, w_b_idx} = f_sel(i_req & ~r_gnt, w_ptr_inc);
   end

   // Next-state logic; flush overrides every transition but keeps the pointer.
   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_gnt_idx_nxt = r_gnt_idx;
      w_ptr_nxt     = r_ptr;
      w_cnt_nxt     = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_a_found) begin
               w_state_nxt   = S_GRANT;
               w_gnt_nxt     = f_oh(w_a_idx);
               w_gnt_idx_nxt = w_a_idx;
            end
         end
         S_GRANT: begin
            if (i_fu_ready) begin
               w_ptr_nxt = w_ptr_inc;
               if (LAT > 1) begin
                  w_state_nxt   = S_BUSY;
                  w_gnt_nxt     = '0;
                  w_gnt_idx_nxt = '0;
                  w_cnt_nxt     = CW'(LAT - 1);
               end else if (w_b_found) begin
                  w_gnt_nxt     = f_oh(w_b_idx);
                  w_gnt_idx_nxt = w_b_idx;
               end else begin
                  w_state_nxt   = S_IDLE;
                  w_gnt_nxt     = '0;
                  w_gnt_idx_nxt = '0;
               end
            end else if (!i_req[r_gnt_idx]) begin
               // Requester squashed before the FU took it: drop the grant.
               w_state_nxt   = S_IDLE;
               w_gnt_nxt     = '0;
               w_gnt_idx_nxt = '0;
            end
         end
         S_BUSY: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
               if (w_a_found) begin
                  w_state_nxt   = S_GRANT;
                  w_gnt_nxt     = f_oh(w_a_idx);
                  w_gnt_idx_nxt = w_a_idx;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_gnt_nxt     = '0;
            w_gnt_idx_nxt = '0;
            w_cnt_nxt     = '0;
         end
      endcase
      if (i_flush) begin
         w_state_nxt   = S_IDLE;
         w_gnt_nxt     = '0;
         w_gnt_idx_nxt = '0;
         w_cnt_nxt     = '0;
         w_ptr_nxt     = r_ptr;
      end
   end

   // State, grant, pointer and occupancy registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_gnt_idx <= '0;
         r_ptr     <= '0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_gnt_idx <= w_gnt_idx_nxt;
         r_ptr     <= w_ptr_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign o_gnt       = r_gnt;
   assign o_gnt_idx   = r_gnt_idx;
   assign o_gnt_valid = (r_state == S_GRANT);
   assign o_busy      = (r_state == S_BUSY);
   assign o_issue     = o_gnt_valid & i_fu_ready;

endmodule

// File: tb/tb_fu_rr_arbiter.sv
// Bench for fu_rr_arbiter: one instance with LAT=4 and one with LAT=1.
// Expected grant indices are queued by the stimulus; a monitor pops one per
// observed issue and also checks the grant invariants every cycle.
module tb_fu_rr_arbiter;
   localparam int N  = 16;
   localparam int IW = $clog2(N);

   logic          clk, rst_n;
   logic [N-1:0]  r4, r1;
   logic          fr4, fr1, fl4, fl1;
   logic [N-1:0]  gnt4, gnt1;
   logic [IW-1:0] gidx4, gidx1;
   logic          gv4, gv1, iss4, iss1, busy4, busy1;

   int n_chk = 0;
   int n_err = 0;
   int q4[$];
   int q1[$];

   fu_rr_arbiter #(.N(N), .LAT(4)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(r4), .i_fu_ready(fr4), .i_flush(fl4),
      .o_gnt(gnt4), .o_gnt_idx(gidx4), .o_gnt_valid(gv4), .o_issue(iss4), .o_busy(busy4));

   fu_rr_arbiter #(.N(N), .LAT(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(r1), .i_fu_ready(fr1), .i_flush(fl1),
      .o_gnt(gnt1), .o_gnt_idx(gidx1), .o_gnt_valid(gv1), .o_issue(iss1), .o_busy(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard pops on every issue, plus per-cycle invariants.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("dut4 gnt onehot0", {63'd0, $onehot0(gnt4)}, 64'd1);
         chk("dut1 gnt onehot0", {63'd0, $onehot0(gnt1)}, 64'd1);
         chk("dut4 valid&busy", {63'd0, gv4 & busy4}, 64'd0);
         if (!gv4) chk("dut4 gnt idle zero", {48'd0, gnt4}, 64'd0);
         if (!gv1) chk("dut1 gnt idle zero", {48'd0, gnt1}, 64'd0);
         if (iss4) begin
            if (q4.size() == 0) chk("dut4 unexpected issue idx", 64'(gidx4), 64'hFFFF);
            else begin
               int e;
               e = q4.pop_front();
               chk("dut4 issue idx", 64'(gidx4), 64'(e));
               chk("dut4 issue gnt", {48'd0, gnt4}, 64'd1 << e);
            end
         end
         if (iss1) begin
            if (q1.size() == 0) chk("dut1 unexpected issue idx", 64'(gidx1), 64'hFFFF);
            else begin
               int e;
               e = q1.pop_front();
               chk("dut1 issue idx", 64'(gidx1), 64'(e));
               chk("dut1 issue gnt", {48'd0, gnt1}, 64'd1 << e);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      r4 = '0; r1 = '0; fr4 = 1'b0; fr1 = 1'b0; fl4 = 1'b0; fl1 = 1'b0;
      #3;
      chk("reset gnt4", {48'd0, gnt4}, 64'd0);
      chk("reset gidx4", 64'(gidx4), 64'd0);
      chk("reset gv4", {63'd0, gv4}, 64'd0);
      chk("reset busy4", {63'd0, busy4}, 64'd0);
      chk("reset issue4", {63'd0, iss4}, 64'd0);
      chk("reset gv1", {63'd0, gv1}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nxt();

      // basic grant, accept and LAT=4 occupancy
      r4 = 16'h0010; fr4 = 1'b1; q4.push_back(4);
      @(negedge clk); chk("idle before grant gv4", {63'd0, gv4}, 64'd0);
      nxt(); r4 = '0;
      @(negedge clk);
      chk("first grant gv4", {63'd0, gv4}, 64'd1);
      chk("first grant gnt4", {48'd0, gnt4}, 64'h10);
      for (int i = 0; i < 3; i++) begin
         nxt();
         @(negedge clk); chk("busy window busy4", {63'd0, busy4}, 64'd1);
      end
      nxt();
      @(negedge clk);
      chk("after busy busy4", {63'd0, busy4}, 64'd0);
      chk("after busy gv4", {63'd0, gv4}, 64'd0);
      // ptr must now be 5: bits 4,5 requested -> 5 wins
      r4 = 16'h0030; q4.push_back(5);
      nxt(); r4 = '0;
      repeat (4) nxt();
      @(negedge clk); chk("idle after 5 busy4", {63'd0, busy4}, 64'd0);

      // serve idx 2 so ptr=3, then withdrawal on idx 3
      r4 = 16'h0004; q4.push_back(2);
      nxt(); r4 = '0;
      repeat (4) nxt();
      r4 = 16'h0008; fr4 = 1'b0;
      nxt();
      r4 = 16'h0024;
      @(negedge clk);
      chk("withdraw pre gv4", {63'd0, gv4}, 64'd1);
      chk("withdraw pre gidx4", 64'(gidx4), 64'd3);
      chk("withdraw pre issue4", {63'd0, iss4}, 64'd0);
      nxt();
      fr4 = 1'b1; q4.push_back(5); q4.push_back(2);
      @(negedge clk);
      chk("withdraw gv4", {63'd0, gv4}, 64'd0);
      chk("withdraw gidx4", 64'(gidx4), 64'd0);
      repeat (6) nxt();
      r4 = '0;
      repeat (3) nxt();
      @(negedge clk); chk("after withdraw idle busy4", {63'd0, busy4}, 64'd0);

      // flush one cycle after accept; ptr=3 -> grant 6, then ptr=7
      r4 = 16'h0040; q4.push_back(6);
      nxt(); r4 = 16'h0081;
      nxt(); fl4 = 1'b1;
      @(negedge clk); chk("flush pre busy4", {63'd0, busy4}, 64'd1);
      nxt(); fl4 = 1'b0; q4.push_back(7);
      @(negedge clk);
      chk("flush busy4", {63'd0, busy4}, 64'd0);
      chk("flush gv4", {63'd0, gv4}, 64'd0);
      nxt(); r4 = '0;
      @(negedge clk); chk("post flush gv4", {63'd0, gv4}, 64'd1);
      repeat (4) nxt();

      // async reset while in GRANT; ptr=8 gives 8 first, after reset 3
      r4 = 16'h0108; fr4 = 1'b0;
      nxt();
      @(negedge clk);
      chk("pre reset gv4", {63'd0, gv4}, 64'd1);
      chk("pre reset gidx4", 64'(gidx4), 64'd8);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset gv4", {63'd0, gv4}, 64'd0);
      chk("async reset gnt4", {48'd0, gnt4}, 64'd0);
      chk("async reset gidx4", 64'(gidx4), 64'd0);
      chk("async reset issue4", {63'd0, iss4}, 64'd0);
      chk("async reset busy4", {63'd0, busy4}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      nxt();
      fr4 = 1'b1; r4 = '0; q4.push_back(3);
      repeat (5) nxt();

      // LAT=1 fairness: 0..15 then 0, one issue per cycle
      r1 = 16'hFFFF; fr1 = 1'b1;
      for (int i = 0; i < 16; i++) q1.push_back(i);
      q1.push_back(0);
      repeat (17) nxt();
      r1 = '0;
      nxt();
      @(negedge clk);
      chk("fair end gv1", {63'd0, gv1}, 64'd0);
      chk("lat1 busy1", {63'd0, busy1}, 64'd0);

      // LAT=1 wrap: serve 14 (ptr=15), then 0x8001 -> 15, 0, 15
      r1 = 16'h4000; q1.push_back(14);
      nxt();
      r1 = 16'h8001; q1.push_back(15); q1.push_back(0); q1.push_back(15);
      repeat (3) nxt();
      r1 = '0;
      nxt();
      @(negedge clk); #1;
      chk("wrap end gv1", {63'd0, gv1}, 64'd0);
      chk("dut4 queue drained", 64'(q4.size()), 64'd0);
      chk("dut1 queue drained", 64'(q1.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
